// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// FSM state encoding used by div_seq_int.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_rstep.sv
// One combinational restoring-division step.
// Subtracts the divisor from the partial remainder and restores on borrow.
module div_rstep #(
    parameter int DW = 16
) (
    input  logic [DW:0]   pr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] rem,
    output logic          qbit
);

    logic [DW:0] sb;

    assign sb   = pr - {1'b0, d};
    assign qbit = ~sb[DW];
    assign rem  = qbit ? sb[DW-1:0] : pr[DW-1:0];

endmodule

// File: rtl/div_seq_int.sv
// Multi-cycle signed/unsigned restoring divider, one op in flight.
// Results are held in output registers until the next operation finishes.
module div_seq_int
    import div_pkg::*;
#(
    parameter int ZW        = 28,
    parameter int DW        = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startp,
    input  logic          sgn,
    input  logic [ZW-1:0] z,
    input  logic [DW-1:0] d,
    output logic [ZW-1:0] q,
    output logic [DW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic          ov
);

    localparam int CW = $clog2(ZW + 1);
    localparam int WW = ZW + DW;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [WW-1:0] work_q;
    logic [DW-1:0] dm_q;
    logic [DW-1:0] zlo_q;
    logic          sz_q;
    logic          sd_q;
    logic          zero_q;
    logic          ovf_q;

    logic [ZW-1:0] q_q;
    logic [DW-1:0] r_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;
    logic          ov_q;

    logic          sgn_e;
    logic          sz_d;
    logic          sd_d;
    logic [ZW-1:0] zm_d;
    logic [DW-1:0] dm_d;
    logic          ovf_d;

    logic [DW-1:0] rem_s;
    logic          qbit_s;
    logic [WW-1:0] work_d;
    logic [ZW-1:0] qm;
    logic [DW-1:0] rm;
    logic [ZW-1:0] q_fix;
    logic [DW-1:0] r_fix;

    // With SIGNED_EN=0 the sign flags are constant zero and negation folds away.
    assign sgn_e = (SIGNED_EN != 0) & sgn;
    assign sz_d  = sgn_e & z[ZW-1];
    assign sd_d  = sgn_e & d[DW-1];
    assign zm_d  = sz_d ? -z : z;
    assign dm_d  = sd_d ? -d : d;
    assign ovf_d = sgn_e & (z == {1'b1, {(ZW-1){1'b0}}}) & (&d);

    div_rstep #(
        .DW(DW)
    ) u_step (
        .pr  (work_q[WW-1:ZW-1]),
        .d   (dm_q),
        .rem (rem_s),
        .qbit(qbit_s)
    );

    assign work_d = {rem_s, work_q[ZW-2:0], qbit_s};
    assign qm     = work_q[ZW-1:0];
    assign rm     = work_q[WW-1:ZW];
    assign q_fix  = (sz_q ^ sd_q) ? -qm : qm;
    assign r_fix  = sz_q ? -rm : rm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dm_q    <= '0;
            zlo_q   <= '0;
            sz_q    <= 1'b0;
            sd_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (startp) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(ZW);
                        work_q  <= {{DW{1'b0}}, zm_d};
                        dm_q    <= dm_d;
                        zlo_q   <= z[DW-1:0];
                        sz_q    <= sz_d;
                        sd_q    <= sd_d;
                        zero_q  <= (d == '0);
                        ovf_q   <= ovf_d;
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dz_q    <= zero_q;
                    ov_q    <= ovf_q & ~zero_q;
                    if (zero_q) begin
                        q_q <= '1;
                        r_q <= zlo_q;
                    end else if (ovf_q) begin
                        q_q <= {1'b1, {(ZW-1){1'b0}}};
                        r_q <= '0;
                    end else begin
                        q_q <= q_fix;
                        r_q <= r_fix;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_div_seq_int.sv
// Self-checking bench for div_seq_int with a plain-arithmetic model.
// Directed scenarios plus randomized operations in both modes.
module tb_div_seq_int;

    localparam int ZW = 28;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          startp;
    logic          sgn;
    logic [ZW-1:0] z;
    logic [DW-1:0] d;
    logic [ZW-1:0] q;
    logic [DW-1:0] r;
    logic          busy;
    logic          done;
    logic          dz;
    logic          ov;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    div_seq_int #(
        .ZW(ZW),
        .DW(DW),
        .SIGNED_EN(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .startp(startp),
        .sgn   (sgn),
        .z     (z),
        .d     (d),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ov    (ov)
    );

    function automatic void model(
        input  logic          s,
        input  logic [ZW-1:0] zv,
        input  logic [DW-1:0] dv,
        output logic [ZW-1:0] eq,
        output logic [DW-1:0] er,
        output logic          edz,
        output logic          eov
    );
        longint zi, di, qi, ri;
        edz = 1'b0;
        eov = 1'b0;
        if (s) begin
            zi = longint'($signed(zv));
            di = longint'($signed(dv));
        end else begin
            zi = longint'({36'd0, zv});
            di = longint'({48'd0, dv});
        end
        if (di == 0) begin
            edz = 1'b1;
            eq  = '1;
            er  = zv[DW-1:0];
        end else if (s && zi == -134217728 && di == -1) begin
            eov = 1'b1;
            eq  = 28'h8000000;
            er  = '0;
        end else begin
            qi = zi / di;
            ri = zi % di;
            eq = qi[ZW-1:0];
            er = ri[DW-1:0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(
        input logic          s,
        input logic [ZW-1:0] zv,
        input logic [DW-1:0] dv
    );
        sgn    = s;
        z      = zv;
        d      = dv;
        startp = 1'b1;
        step();
        startp = 1'b0;
    endtask

    // l = edges since the accepting edge, b = cycles seen with busy high
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        while (done !== 1'b1 && l < 40) begin
            if (busy === 1'b1) b++;
            step();
            l++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        startp = 1'b0;
        sgn    = 1'b0;
        z      = '0;
        d      = '0;
        repeat (3) step();
        tests_run++;
        if ({q, r, busy, done, dz, ov} !== '0) begin
            fails++;
            $display("FAIL reset_state: got q=%h r=%h b=%b dn=%b dz=%b ov=%b, want all 0",
                     q, r, busy, done, dz, ov);
        end
        startp = 1'b1;
        z      = 28'd100;
        d      = 16'd7;
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_over_start: busy=%b, want 0", busy);
        end
        startp = 1'b0;
        rst    = 1'b0;
        step();
    endtask

    task automatic test_unsigned();
        int l, b;
        launch(1'b0, 28'd100, 16'd7);
        wait_done(l, b);
        tests_run++;
        if (l != 29) begin
            fails++;
            $display("FAIL unsigned_latency: got %0d, want 29", l);
        end
        tests_run++;
        if (b != 29 || busy !== 1'b0) begin
            fails++;
            $display("FAIL unsigned_busy: cycles=%0d busy_at_done=%b, want 29 and 0", b, busy);
        end
        tests_run++;
        if ({q, r, dz, ov} !== {28'd14, 16'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL unsigned_result: q=%0d r=%0d dz=%b ov=%b, want 14 2 0 0",
                     q, r, dz, ov);
        end
        step();
        tests_run++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b a cycle later, want 0", done);
        end
    endtask

    task automatic test_signed();
        int l, b;
        launch(1'b1, 28'hFFFFF9C, 16'd7);
        wait_done(l, b);
        tests_run++;
        if ({q, r, dz, ov} !== {28'hFFFFFF2, 16'hFFFE, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL signed_neg_z: q=%h r=%h dz=%b ov=%b, want FFFFFF2 FFFE 0 0",
                     q, r, dz, ov);
        end
        launch(1'b1, 28'd100, 16'hFFF9);
        wait_done(l, b);
        tests_run++;
        if ({q, r, dz, ov} !== {28'hFFFFFF2, 16'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL signed_neg_d: q=%h r=%h dz=%b ov=%b, want FFFFFF2 0002 0 0",
                     q, r, dz, ov);
        end
    endtask

    task automatic test_div_zero();
        int l, b;
        for (int s = 0; s < 2; s++) begin
            launch(s[0], 28'h1234567, 16'd0);
            wait_done(l, b);
            tests_run++;
            if ({q, r, dz, ov} !== {28'hFFFFFFF, 16'h4567, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL div_zero sgn=%0d: q=%h r=%h dz=%b ov=%b, want FFFFFFF 4567 1 0",
                         s, q, r, dz, ov);
            end
        end
    endtask

    task automatic test_overflow();
        int l, b;
        launch(1'b1, 28'h8000000, 16'hFFFF);
        wait_done(l, b);
        tests_run++;
        if ({q, r, dz, ov} !== {28'h8000000, 16'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL overflow: q=%h r=%h dz=%b ov=%b, want 8000000 0000 0 1",
                     q, r, dz, ov);
        end
    endtask

    task automatic test_abort();
        int seen;
        launch(1'b0, 28'd1000, 16'd3);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if ({busy, done, q, r} !== '0) begin
            fails++;
            $display("FAIL abort_state: busy=%b done=%b q=%h r=%h, want all 0",
                     busy, done, q, r);
        end
        seen = 0;
        repeat (35) begin
            step();
            if (done === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_done: %0d done pulses, want 0", seen);
        end
    endtask

    task automatic test_busy_ignore();
        int l;
        launch(1'b0, 28'd1000, 16'd9);
        l = 0;
        while (done !== 1'b1 && l < 40) begin
            startp = (l == 5 || l == 15);
            if (startp) begin
                sgn = 1'b1;
                z   = 28'($urandom);
                d   = 16'd1;
            end
            step();
            l++;
        end
        startp = 1'b0;
        tests_run++;
        if (l != 29) begin
            fails++;
            $display("FAIL ignore_latency: got %0d, want 29", l);
        end
        tests_run++;
        if ({q, r, dz, ov} !== {28'd111, 16'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL ignore_result: q=%0d r=%0d dz=%b ov=%b, want 111 1 0 0",
                     q, r, dz, ov);
        end
    endtask

    task automatic test_back_to_back();
        int l, b, bad;
        launch(1'b0, 28'hFFFFFFF, 16'd1);
        wait_done(l, b);
        tests_run++;
        if ({q, r} !== {28'hFFFFFFF, 16'd0}) begin
            fails++;
            $display("FAIL b2b_first: q=%h r=%h, want FFFFFFF 0000", q, r);
        end
        launch(1'b0, 28'd50, 16'd5);
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        l   = 0;
        bad = 0;
        while (done !== 1'b1 && l < 40) begin
            if (q !== 28'hFFFFFFF || r !== 16'd0) bad++;
            step();
            l++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_hold: %0d cycles changed, want 0", bad);
        end
        tests_run++;
        if (l != 29 || {q, r} !== {28'd10, 16'd0}) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want 29 10 0", l, q, r);
        end
    endtask

    task automatic test_random();
        int l, b, sel;
        logic          s;
        logic [ZW-1:0] zv, eq;
        logic [DW-1:0] dv, er;
        logic          edz, eov;
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            zv  = 28'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0: dv = '0;
                1: dv = 16'd1;
                2: begin
                    dv = '1;
                    if ($urandom_range(0, 1) == 1) zv = 28'h8000000;
                end
                3: dv = 16'($urandom_range(1, 20));
                default: dv = 16'($urandom);
            endcase
            model(s, zv, dv, eq, er, edz, eov);
            launch(s, zv, dv);
            wait_done(l, b);
            tests_run++;
            if (l != 29 || {q, r, dz, ov} !== {eq, er, edz, eov}) begin
                fails++;
                $display("FAIL rand%0d s=%b z=%h d=%h: lat=%0d q=%h r=%h dz=%b ov=%b, want 29 %h %h %b %b",
                         i, s, zv, dv, l, q, r, dz, ov, eq, er, edz, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/div_seq_int.md
Name: div_seq_int

Overview:
- Parametrised multi-cycle restoring divider; next generation of the fixed 28b/16b integer divider.
- Adds generic widths, per-operation signed/unsigned mode and a one-cycle done pulse.
- Adds divide-by-zero and signed-overflow flags, and result registers that hold the previous result while a new division runs.
- Sits beside the control datapath; one division in flight, started by a single-cycle pulse.

Parameters:
- ZW, 28, dividend and quotient width; must be >= DW.
- DW, 16, divisor and remainder width; must be >= 2.
- SIGNED_EN, 1, 1 = sgn input honoured; 0 = sgn ignored and treated as 0, with sign logic removed.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- startp  in  1  start pulse; sampled only when busy=0
- sgn  in  1  mode, sampled with startp: 0 = unsigned, 1 = two's-complement signed
- z  in  ZW  dividend, sampled with startp
- d  in  DW  divisor, sampled with startp
- q  out  ZW  quotient, registered
- r  out  DW  remainder, registered
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; q/r/dz/ov valid from this cycle on
- dz  out  1  divisor was zero
- ov  out  1  signed overflow

Behaviour:
- Reset: rst is synchronous, active-high, and overrides everything including startp.
  - State goes to IDLE.
  - q=0, r=0, busy=0, done=0, dz=0, ov=0.
  - Working registers are cleared.
- States:
  - IDLE: waits for startp.
  - RUN: performs ZW iterations, counter counting ZW down to 1, counter width $clog2(ZW+1).
  - FIX: performs sign and exception correction, then writes the result registers.
- IDLE to RUN (startp=1 at edge k):
  - Latch magnitudes |z| (ZW bits unsigned) and |d| (DW bits unsigned) when sgn=1; latch raw values when sgn=0.
  - Latch sz, sd and sgn.
  - Working register is ZW+DW bits: {DW'0, |z|}.
- RUN (edges k+1 .. k+ZW), one restoring step per edge:
  - pr = work[ZW+DW-1:ZW-1], DW+1 bits.
  - sb = pr - {0,|d|}.
  - If sb < 0: keep pr[DW-1:0]; quotient bit = 0.
  - Otherwise: keep sb[DW-1:0]; quotient bit = 1.
  - Shift the quotient bit into the LSB.
- FIX (edge k+ZW+1): one step; results are written to q/r/dz/ov, state returns to IDLE, done=1 for exactly one cycle.
  - d==0: dz=1, q=all ones, r=z[DW-1:0] (raw input bits), ov=0. Holds in both modes.
  - sgn=1, z=-2^(ZW-1), d=-1: ov=1, q=2^(ZW-1) (bit pattern of most negative), r=0.
  - Other signed cases use truncation toward zero:
    - q negated if sz^sd.
    - r negated if sz.
  - Unsigned case: magnitudes are passed through unchanged.
- busy:
  - 1 in the cycles after edges k .. k+ZW, i.e. ZW+1 cycles.
  - 0 in the done cycle.
- Latency: startp edge to done = ZW+1 clocks (29 for defaults).
- Result holding:
  - q/r/dz/ov hold the last result until the next FIX.
  - They are unchanged during RUN.
- startp while busy=1: ignored; no restart and no effect on the current operation.
- startp in the done cycle: accepted, since state is IDLE. done is high that cycle and busy goes high the next.
- rst mid-operation: aborts immediately to the reset state; the previous result is cleared.
- Width rule: all subtraction is DW+1 bits. Signed magnitude of the most negative value fits the unsigned ZW or DW bits.

Decomposition:
- Package div_pkg holds:
  - State encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_FIX=2'd2.
  - A clog2 helper function if the tool lacks $clog2.
- One sub-module, div_rstep: combinational single restoring step, parameter DW.
  - Inputs: pr[DW:0] and d[DW-1:0].
  - Outputs: rem[DW-1:0] and qbit.
- Sign and abs handling and the FSM stay in div_seq_int.

Test Plan (defaults ZW=28, DW=16):
- Unsigned: sgn=0, z=100, d=7 -> after 29 clocks done=1, q=14, r=2, dz=0, ov=0; busy high for exactly 29 cycles.
- Signed: sgn=1, z=0xFFFFF9C (-100), d=7 -> q=0xFFFFFF2 (-14), r=0xFFFE (-2). Then z=100, d=0xFFF9 (-7) -> q=0xFFFFFF2, r=2.
- Divide by zero: z=0x1234567, d=0, sgn=0 and sgn=1 -> dz=1, q=0xFFFFFFF, r=0x4567, ov=0.
- Signed overflow: sgn=1, z=0x8000000, d=0xFFFF -> ov=1, q=0x8000000, r=0, dz=0.
- Control: rst asserted at RUN iteration 10 -> next cycle busy=0, q=r=0, no done. startp pulses while busy -> ignored, result of first operation unchanged.
- Back-to-back: z=0xFFFFFFF, d=1 started; second startp (z=50, d=5) in the done cycle -> first q=0xFFFFFFF r=0 held through the second run, then q=10 r=0 after 29 more clocks.
